// File: rtl/cla_subtractor_pipe_16_if.sv
// Streaming handshake bundle for cla_subtractor_pipe_16: operand side (in_*, a, b, bin)
// and result side (out_*, diff, bout, ovf).
interface cla_subtractor_pipe_16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/cla_subtractor_pipe_16.sv
// Two-stage pipelined CLA subtractor: diff = a - b - bin, computed as a + ~b + ~bin.
// Optional macro CLA_SUB_SATURATE_EN: signed saturation of diff on overflow.
module cla_subtractor_pipe_16 #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  cla_subtractor_pipe_16_if.slave bus
);
  localparam int HALF = WIDTH / 2;
  localparam int NG   = HALF / 4;

  // 4-bit carry-lookahead group cell: returns {cout, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       co;
    p    = x ^ y;
    g    = x & y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {co, p ^ c};
  endfunction

  logic             s1_valid_q;
  logic [HALF-1:0]  s1_lo_q;
  logic             s1_cmid_q;
  logic [HALF-1:0]  s1_ahi_q;
  logic [HALF-1:0]  s1_bnhi_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic [HALF-1:0]  lo_sum_d;
  logic             cmid_d;
  logic [HALF-1:0]  hi_sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] raw_diff_d;
  logic [WIDTH-1:0] diff_d;
  logic             ovf_d;
  logic             a_top;
  logic             b_top;

  logic accept;
  logic s2_adv;

  assign s2_adv       = s1_valid_q & (~s2_valid_q | bus.out_ready);
  assign bus.in_ready = ~s1_valid_q | s2_adv;
  assign accept       = bus.in_valid & bus.in_ready;

  // Lower half: ripple the group carries starting from the inverted borrow-in.
  always_comb begin
    logic       c;
    logic [4:0] r;
    lo_sum_d = '0;
    c        = ~bus.bin;
    r        = '0;
    for (int i = 0; i < NG; i++) begin
      r                 = cla4(bus.a[i*4 +: 4], ~bus.b[i*4 +: 4], c);
      lo_sum_d[i*4 +: 4] = r[3:0];
      c                 = r[4];
    end
    cmid_d = c;
  end

  // Upper half continues from the registered half-carry.
  always_comb begin
    logic       c;
    logic [4:0] r;
    hi_sum_d = '0;
    c        = s1_cmid_q;
    r        = '0;
    for (int i = 0; i < NG; i++) begin
      r                 = cla4(s1_ahi_q[i*4 +: 4], s1_bnhi_q[i*4 +: 4], c);
      hi_sum_d[i*4 +: 4] = r[3:0];
      c                 = r[4];
    end
    cout_d = c;
  end

  always_comb begin
    a_top      = s1_ahi_q[HALF-1];
    b_top      = ~s1_bnhi_q[HALF-1];
    raw_diff_d = {hi_sum_d, s1_lo_q};
    ovf_d      = (a_top ^ b_top) & (raw_diff_d[WIDTH-1] ^ a_top);
    diff_d     = raw_diff_d;
`ifdef CLA_SUB_SATURATE_EN
    if (ovf_d) begin
      diff_d = a_top ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_cmid_q  <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bnhi_q  <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_lo_q    <= lo_sum_d;
        s1_cmid_q  <= cmid_d;
        s1_ahi_q   <= bus.a[WIDTH-1:HALF];
        s1_bnhi_q  <= ~bus.b[WIDTH-1:HALF];
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_adv) begin
        s2_valid_q <= 1'b1;
        diff_q     <= diff_d;
        bout_q     <= ~cout_d;
        ovf_q      <= ovf_d;
      end else if (bus.out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/cla_subtractor_pipe_16.md
Name: cla_subtractor_pipe_16

Overview:
- Two-stage pipelined subtractor: diff = a - b - bin.
- Built on the team's 4-bit carry-lookahead group cells.
- Computes a + ~b + ~bin, with the carry out inverted to form the borrow.
- Pipeline split at the half-word boundary; the half-carry is registered between stages.
- Valid/ready handshake on both sides so it drops into streaming datapaths beside the CLA adders.

Parameters:
WIDTH, 16, operand width; must be a multiple of 8; stage 1 handles bits [WIDTH/2-1:0], stage 2 handles [WIDTH-1:WIDTH/2]

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands a, b, bin valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in (1 = subtract an extra 1)
out_valid  output  1  result fields valid
out_ready  input  1  downstream accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow out = ~carry out of the top group; 1 when unsigned a < b + bin
ovf  output  1  two's-complement overflow of the signed subtraction

Behaviour:
- Reset (async assert; release synchronous to clk):
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - diff, bout, ovf = 0.
  - in_ready = 1 in the first cycle after reset release.
- Stage 1 register, loaded on in_valid & in_ready:
  - lower-half difference from the CLA groups, cin = ~bin;
  - half-carry c_mid;
  - upper halves of a and ~b held raw.
- Stage 2 register, loaded when stage 1 advances:
  - upper-half CLA sum, cin = c_mid;
  - lower half passed through;
  - bout = ~cout;
  - ovf = (a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1]).
- Stage 2 drives the outputs directly (registered outputs, no combinational path from a/b to the outputs).
- Advance rules:
  - s2_adv = s1_valid & (~s2_valid | out_ready)
  - in_ready = ~s1_valid | s2_adv (combinational from out_ready; no other comb paths)
- Latency: 2 cycles from the accept edge to out_valid. Throughput is 1 result per cycle while out_ready = 1.
- Backpressure:
  - With out_ready = 0, the pipeline holds up to 2 transactions.
  - in_ready falls once both stages are full.
  - out_valid and the output fields stay stable until the handshake completes.
- Simultaneous events:
  - If an output handshake and an input accept happen in the same cycle, both complete and the occupancy is unchanged.
  - Data is never dropped or duplicated.
- in_valid while in_ready = 0: ignored. The upstream must hold its operands stable.
- Reset mid-operation: all in-flight transactions are discarded and the outputs clear immediately (asynchronous).
- Arithmetic:
  - Results wrap modulo 2^WIDTH.
  - bin = 1 with a = b gives all ones, bout = 1.

Optional Feature:
- Macro: CLA_SUB_SATURATE_EN.
- Defined:
  - When ovf = 1, diff is replaced by a signed saturated value: 0x8000 (WIDTH-scaled minimum) if a[W-1] = 1, else 0x7FFF (WIDTH-scaled maximum).
  - ovf is still reported.
  - bout is unchanged (always the raw borrow).
- Undefined: diff is the wrapped result.
- Latency and handshake are identical in both builds.

Test Plan:
1. a=0x0005, b=0x0003, bin=0 -> two cycles after accept: diff=0x0002, bout=0, ovf=0.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x0100, b=0x0001 -> diff=0x00FF (borrow crosses the stage boundary).
3. a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0. With CLA_SUB_SATURATE_EN: diff=0x8000, ovf=1.
4. a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
5. Streaming with backpressure:
   - Stimulus: 4 back-to-back inputs (0x0010-i for i=0..3); out_ready low for cycles 2-4, then high.
   - Required: in_ready drops after 2 accepts; outputs held stable while stalled; all 4 results delivered in order with no loss or duplication.
6. Reset mid-operation:
   - Stimulus: assert rst asynchronously while 2 transactions are in flight.
   - Required: out_valid=0 and diff=0 immediately; in_ready=1 in the cycle after release; a new transaction returns its result exactly 2 cycles after accept.
